hdmi_period_scheduler: RTL

Raster timing and HDMI period sequencer. It drives the three TMDS channel encoders and the pixel source in the HDMI transmitter. It generates the h/v counters, sync, data-enable and pixel coordinates. It also schedules each pixel clock as a control, video-preamble, video-guard-band or video-data period, and supplies the CTL bits the encoders need. Start and stop are frame-aligned under an enable input, so the TMDS link never sees a truncated frame.

---
 rtl/hdmi_timing_pkg.sv | 39 +++
 rtl/hdmi_raster_counter.sv | 56 +++++
 rtl/hdmi_period_scheduler.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/hdmi_timing_pkg.sv
// Shared HDMI timing definitions: period codes, FSM states, CTL constants
// and the 640x480@60 default raster.
package hdmi_timing_pkg;

  typedef enum logic [1:0] {
    PERIOD_CTRL     = 2'd0,
    PERIOD_PREAMBLE = 2'd1,
    PERIOD_GUARD    = 2'd2,
    PERIOD_VIDEO    = 2'd3
  } period_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sched_state_e;

  localparam logic [3:0] CTL_VIDEO_PREAMBLE = 4'b0001;
  localparam logic [3:0] CTL_NONE           = 4'b0000;

  localparam int unsigned PREAMBLE_LEN = 8;
  localparam int unsigned GUARD_LEN    = 2;
  localparam int unsigned COORD_W      = 10;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int raster_total(input int active, input int fp,
                                      input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/hdmi_raster_counter.sv
// Horizontal/vertical raster counters with hold, reload-to-start and frame-wrap flag.
module hdmi_raster_counter #(
  parameter int H_TOTAL = 800,
  parameter int V_TOTAL = 525,
  parameter int HW      = 10,
  parameter int VW      = 10
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          hold_i,
  input  logic          load_start_i,
  output logic [HW-1:0] cx_o,
  output logic [VW-1:0] cy_o,
  output logic          frame_wrap_o
);

  localparam logic [HW-1:0] CX_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] CY_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] cx_q, cx_d;
  logic [VW-1:0] cy_q, cy_d;
  logic          line_wrap;

  assign line_wrap    = (cx_q == CX_LAST);
  assign frame_wrap_o = line_wrap && (cy_q == CY_LAST);
  assign cx_o         = cx_q;
  assign cy_o         = cy_q;

  // The start position is the last blanking line so every frame opens with a preamble line.
  always_comb begin
    cx_d = cx_q;
    cy_d = cy_q;
    if (load_start_i) begin
      cx_d = '0;
      cy_d = CY_LAST;
    end else if (!hold_i) begin
      if (line_wrap) begin
        cx_d = '0;
        cy_d = (cy_q == CY_LAST) ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cx_q <= '0;
      cy_q <= CY_LAST;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

endmodule

// File: rtl/hdmi_period_scheduler.sv
// Raster timing generator and HDMI period sequencer with frame-aligned start/stop.
module hdmi_period_scheduler
  import hdmi_timing_pkg::*;
#(
  parameter int H_ACTIVE         = DEF_H_ACTIVE,
  parameter int H_FP             = DEF_H_FP,
  parameter int H_SYNC           = DEF_H_SYNC,
  parameter int H_BP             = DEF_H_BP,
  parameter int V_ACTIVE         = DEF_V_ACTIVE,
  parameter int V_FP             = DEF_V_FP,
  parameter int V_SYNC           = DEF_V_SYNC,
  parameter int V_BP             = DEF_V_BP,
  parameter bit SYNC_ACTIVE_HIGH = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  output logic [1:0]         period,
  output logic               de,
  output logic               hsync,
  output logic               vsync,
  output logic [3:0]         ctl,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               frame_start,
  output logic               running
);

  localparam int H_TOTAL = raster_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = raster_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW      = $clog2(H_TOTAL + 1);
  localparam int VW      = $clog2(V_TOTAL + 1);
  localparam int LEADIN  = int'(PREAMBLE_LEN + GUARD_LEN);

  localparam logic [HW-1:0] H_ACT       = HW'(H_ACTIVE);
  localparam logic [HW-1:0] HS_START    = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] HS_END      = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] PRE_START   = HW'(H_TOTAL - LEADIN);
  localparam logic [HW-1:0] GUARD_START = HW'(H_TOTAL - int'(GUARD_LEN));
  localparam logic [VW-1:0] V_ACT       = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_LAST_ACT  = VW'(V_ACTIVE - 1);
  localparam logic [VW-1:0] VS_START    = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS_END      = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] CY_LAST     = VW'(V_TOTAL - 1);
  localparam logic          SYNC_ON     = SYNC_ACTIVE_HIGH;
  localparam logic          SYNC_OFF    = !SYNC_ACTIVE_HIGH;

  // Preamble and guard must fit inside the back porch.
  if (H_BP < LEADIN) begin : g_hbp_check
    $error("hdmi_period_scheduler: H_BP must be at least preamble + guard length");
  end

  sched_state_e  state_q, state_d;
  logic [HW-1:0] cx;
  logic [VW-1:0] cy;
  logic          frame_wrap;
  logic          counting;
  logic          pre_active;

  period_e              period_q, period_d;
  logic                 de_q, de_d;
  logic                 hsync_q, hsync_d;
  logic                 vsync_q, vsync_d;
  logic [3:0]           ctl_q, ctl_d;
  logic [COORD_W-1:0]   x_q, x_d;
  logic [COORD_W-1:0]   y_q, y_d;
  logic                 fs_q, fs_d;
  logic                 running_q, running_d;

  hdmi_raster_counter #(
    .H_TOTAL(H_TOTAL),
    .V_TOTAL(V_TOTAL),
    .HW     (HW),
    .VW     (VW)
  ) u_raster (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .hold_i      (state_q == ST_IDLE),
    .load_start_i((state_q == ST_DRAIN) && frame_wrap),
    .cx_o        (cx),
    .cy_o        (cy),
    .frame_wrap_o(frame_wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (en) state_d = ST_RUN;
      ST_RUN:   if (!en) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (frame_wrap)  state_d = ST_IDLE;
        else if (en)     state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  assign counting = (state_q != ST_IDLE);
  // The blanking line before line 0 only announces video when another frame will follow.
  assign pre_active = (cy < V_LAST_ACT) || ((cy == CY_LAST) && (state_q == ST_RUN));

  always_comb begin
    period_d  = PERIOD_CTRL;
    ctl_d     = CTL_NONE;
    hsync_d   = SYNC_OFF;
    vsync_d   = SYNC_OFF;
    x_d       = '0;
    y_d       = '0;
    fs_d      = 1'b0;
    running_d = counting;
    if (counting) begin
      x_d = COORD_W'(cx);
      y_d = COORD_W'(cy);
      if ((cx >= HS_START) && (cx < HS_END)) hsync_d = SYNC_ON;
      if ((cy >= VS_START) && (cy < VS_END)) vsync_d = SYNC_ON;
      if ((cx < H_ACT) && (cy < V_ACT)) begin
        period_d = PERIOD_VIDEO;
      end else if (pre_active && (cx >= GUARD_START)) begin
        period_d = PERIOD_GUARD;
      end else if (pre_active && (cx >= PRE_START)) begin
        period_d = PERIOD_PREAMBLE;
        ctl_d    = CTL_VIDEO_PREAMBLE;
      end
      fs_d = (cx == '0) && (cy == '0);
    end
    de_d = (period_d == PERIOD_VIDEO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      period_q  <= PERIOD_CTRL;
      de_q      <= 1'b0;
      hsync_q   <= SYNC_OFF;
      vsync_q   <= SYNC_OFF;
      ctl_q     <= CTL_NONE;
      x_q       <= '0;
      y_q       <= '0;
      fs_q      <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      de_q      <= de_d;
      hsync_q   <= hsync_d;
      vsync_q   <= vsync_d;
      ctl_q     <= ctl_d;
      x_q       <= x_d;
      y_q       <= y_d;
      fs_q      <= fs_d;
      running_q <= running_d;
    end
  end

  assign period      = period_q;
  assign de          = de_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign ctl         = ctl_q;
  assign x           = x_q;
  assign y           = y_q;
  assign frame_start = fs_q;
  assign running     = running_q;

endmodule
